video_stream_gen: RTL and testbench

//   Synthesizable source end of the pixel-stream interface: generates raster timing (h_cnt, v_cnt,
//   dv, hs, vs) and 8-bit RGB test patterns. It drives the pixel input of the processing pipeline
//   in hardware bring-up, replacing file-driven stimulus. All outputs are registered and mutually aligned.

---
 rtl/video_pkg.sv | 42 ++++
 rtl/video_sync_counter.sv | 45 ++++
 rtl/video_stream_gen.sv | 144 ++++++++++++++
 tb/tb_video_stream_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern source.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned MAX_TOTAL = 2048;

  // Default 1600x900 timing (1800x1000 total)
  localparam int unsigned DEF_HRES  = 1600;
  localparam int unsigned DEF_VRES  = 900;
  localparam int unsigned DEF_HFP   = 24;
  localparam int unsigned DEF_HSYNC = 80;
  localparam int unsigned DEF_HBP   = 96;
  localparam int unsigned DEF_VFP   = 1;
  localparam int unsigned DEF_VSYNC = 3;
  localparam int unsigned DEF_VBP   = 96;

  // Colour bars, left to right
  localparam rgb_t BAR_TABLE [8] = '{
    '{r: 8'hFF, g: 8'hFF, b: 8'hFF},  // white
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},  // yellow
    '{r: 8'h00, g: 8'hFF, b: 8'hFF},  // cyan
    '{r: 8'h00, g: 8'hFF, b: 8'h00},  // green
    '{r: 8'hFF, g: 8'h00, b: 8'hFF},  // magenta
    '{r: 8'hFF, g: 8'h00, b: 8'h00},  // red
    '{r: 8'h00, g: 8'h00, b: 8'hFF},  // blue
    '{r: 8'h00, g: 8'h00, b: 8'h00}   // black
  };

endpackage

// File: rtl/video_sync_counter.sv
// One raster axis: position counter with active/sync region decode.
module video_sync_counter
  import video_pkg::*;
#(
  parameter int unsigned RES  = DEF_HRES,
  parameter int unsigned FP   = DEF_HFP,
  parameter int unsigned SYNC = DEF_HSYNC,
  parameter int unsigned BP   = DEF_HBP,
  parameter bit          POL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int unsigned TOTAL    = RES + FP + SYNC + BP;
  localparam int unsigned SYNC_BEG = RES + FP;
  localparam int unsigned SYNC_END = RES + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next position: advance on inc, wrap after the last position
  always_comb begin
    wrap  = inc && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (inc) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  // Position register, held at 0 while disabled
  always_ff @(posedge clk) begin
    if (rst || !en) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign active = 32'(cnt_q) < RES;
  assign sync   = ((32'(cnt_q) >= SYNC_BEG) && (32'(cnt_q) < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_stream_gen.sv
// Raster timing and RGB test-pattern source for pixel-pipeline bring-up.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int unsigned HRES   = DEF_HRES,
  parameter int unsigned VRES   = DEF_VRES,
  parameter int unsigned HFP    = DEF_HFP,
  parameter int unsigned HSYNC  = DEF_HSYNC,
  parameter int unsigned HBP    = DEF_HBP,
  parameter int unsigned VFP    = DEF_VFP,
  parameter int unsigned VSYNC  = DEF_VSYNC,
  parameter int unsigned VBP    = DEF_VBP,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       pattern_sel_i,
  input  logic [23:0]      solid_rgb_i,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [7:0]       red_o,
  output logic [7:0]       green_o,
  output logic [7:0]       blue_o,
  output logic             frame_start_o
);

  localparam int unsigned HTOTAL = HRES + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VRES + VFP + VSYNC + VBP;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(HRES / 8 - 1);

  if (HTOTAL > MAX_TOTAL || VTOTAL > MAX_TOTAL) begin : g_bad_timing
    $error("video_stream_gen: HTOTAL/VTOTAL exceed 2048");
  end
  if (HRES < 8) begin : g_bad_hres
    $error("video_stream_gen: HRES must be at least 8 for colour bars");
  end

  logic [CNT_W-1:0] h, v;
  logic             h_act, v_act, h_sync, v_sync, h_wrap, v_wrap;

  video_sync_counter #(
    .RES(HRES), .FP(HFP), .SYNC(HSYNC), .BP(HBP), .POL(HS_POL)
  ) u_h (
    .clk(clk), .rst(rst), .en(en_i), .inc(1'b1),
    .cnt(h), .active(h_act), .sync(h_sync), .wrap(h_wrap)
  );

  video_sync_counter #(
    .RES(VRES), .FP(VFP), .SYNC(VSYNC), .BP(VBP), .POL(VS_POL)
  ) u_v (
    .clk(clk), .rst(rst), .en(en_i), .inc(h_wrap),
    .cnt(v), .active(v_act), .sync(v_sync), .wrap(v_wrap)
  );

  pattern_e         pat_q;
  rgb_t             solid_q;
  logic [7:0]       frame_cnt_q;
  logic [2:0]       bar_idx_q;
  logic [CNT_W-1:0] bar_sub_q;
  rgb_t             pix_d, pix_q;
  logic             dv_d;
  logic             dv_q, hs_q, vs_q, fs_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q;

  // Frame-level state. Pattern controls are captured on the cycle whose
  // successor is pixel (0,0): the v wrap while running, or every idle cycle
  // (counters parked at 0), so pixel (0,0) already uses the new selection.
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      frame_cnt_q <= '0;
      pat_q       <= pattern_e'(pattern_sel_i);
      solid_q     <= rgb_t'(solid_rgb_i);
      bar_idx_q   <= '0;
      bar_sub_q   <= '0;
    end else begin
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        pat_q       <= pattern_e'(pattern_sel_i);
        solid_q     <= rgb_t'(solid_rgb_i);
      end
      // Bar walker tracks the next h: cleared for h==0, steps every BAR_W pixels
      if (h_wrap) begin
        bar_idx_q <= '0;
        bar_sub_q <= '0;
      end else if (bar_sub_q == BAR_LAST) begin
        bar_sub_q <= '0;
        if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_sub_q <= bar_sub_q + CNT_W'(1);
      end
    end
  end

  // Pixel colour for the current counter position, blanked outside active video
  always_comb begin
    dv_d  = h_act && v_act;
    pix_d = '0;
    case (pat_q)
      PAT_SOLID: pix_d = solid_q;
      PAT_RAMP:  pix_d = '{r: h[7:0], g: v[7:0], b: frame_cnt_q};
      PAT_BARS:  pix_d = BAR_TABLE[bar_idx_q];
      PAT_CHECK: pix_d = (h[5] ^ v[5] ^ frame_cnt_q[6]) ? '1 : '0;
      default:   pix_d = '0;
    endcase
    if (!dv_d) pix_d = '0;
  end

  // Output stage: every output describes the same pixel, one clock after the counters
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      dv_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      pix_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h;
      v_cnt_q <= v;
      dv_q    <= dv_d;
      hs_q    <= h_sync;
      vs_q    <= v_sync;
      pix_q   <= pix_d;
      fs_q    <= (h == '0) && (v == '0);
    end
  end

  assign h_cnt         = h_cnt_q;
  assign v_cnt         = v_cnt_q;
  assign dv_o          = dv_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign red_o         = pix_q.r;
  assign green_o       = pix_q.g;
  assign blue_o        = pix_q.b;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Scoreboard bench for video_stream_gen on a 24x8 raster.
module tb_video_stream_gen;

  localparam int HRES = 16, VRES = 4, HFP = 2, HSYNC = 3, HBP = 3;
  localparam int VFP = 1, VSYNC = 2, VBP = 1;
  localparam int HT = 24, VT = 8, FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic [1:0]  pattern_sel_i = 2'd0;
  logic [23:0] solid_rgb_i = 24'h0;
  logic [10:0] h_cnt, v_cnt;
  logic        dv_o, hs_o, vs_o, frame_start_o;
  logic [7:0]  red_o, green_o, blue_o;

  video_stream_gen #(
    .HRES(HRES), .VRES(VRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP), .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .pattern_sel_i(pattern_sel_i),
    .solid_rgb_i(solid_rgb_i), .h_cnt(h_cnt), .v_cnt(v_cnt), .dv_o(dv_o),
    .hs_o(hs_o), .vs_o(vs_o), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Output word: {h, v, dv, hs, vs, rgb, fs}
  logic [49:0] exp_q[$];

  // Reference state
  int          m_h = 0, m_v = 0, m_fc = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_solid = 24'h0;

  int since_fs = -1;
  int line_dv  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pixel(int h, int v, int fc, logic [1:0] pat, logic [23:0] solid);
    int b;
    if (!(h < HRES && v < VRES)) return 24'h0;
    case (pat)
      2'd0: return solid;
      2'd1: return {8'(h), 8'(v), 8'(fc)};
      2'd2: begin
        b = h / 2;
        if (b > 7) b = 7;
        case (b)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      default: return ((((h >> 5) ^ (v >> 5) ^ (fc >> 6)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue the predicted output, then compare it
  task automatic step(input logic r, input logic en, input logic [1:0] pat, input logic [23:0] solid);
    logic [49:0] e, a;
    logic        e_dv;
    rst = r; en_i = en; pattern_sel_i = pat; solid_rgb_i = solid;
    if (r || !en) begin
      e = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0};
      m_h = 0; m_v = 0; m_fc = 0; m_pat = pat; m_solid = solid;
    end else begin
      e_dv = (m_h < HRES) && (m_v < VRES);
      e = {11'(m_h), 11'(m_v), e_dv, (m_h >= 18 && m_h <= 20), !(m_v >= 5 && m_v <= 6),
           pixel(m_h, m_v, m_fc, m_pat, m_solid), (m_h == 0 && m_v == 0)};
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) begin
          m_v = 0;
          m_fc = (m_fc + 1) % 256;
          m_pat = pat;
          m_solid = solid;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a = {h_cnt, v_cnt, dv_o, hs_o, vs_o, red_o, green_o, blue_o, frame_start_o};
    check_eq("out", 64'(a), 64'(exp_q.pop_front()));
    // frame_start_o spacing while running continuously
    if (since_fs >= 0) since_fs++;
    if (frame_start_o) begin
      if (since_fs >= 0) check_eq("fs_period", 64'(since_fs), 64'(FRAME));
      since_fs = 0;
    end
    if (r || !en) since_fs = -1;
    // dv_o count per active line
    if (h_cnt == 11'd0) line_dv = 0;
    if (dv_o) line_dv++;
    if (h_cnt == 11'(HT - 1) && v_cnt < 11'(VRES)) check_eq("line_dv", 64'(line_dv), 64'd16);
  endtask

  initial begin
    logic [1:0]  pat;
    logic [23:0] sol;

    // Reset and idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 24'h123456);
    check_eq("rst_vs", 64'(vs_o), 64'd1);
    check_eq("rst_hs", 64'(hs_o), 64'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'd0, 24'h123456);

    // Start: first output is pixel (0,0) with frame_start
    step(1'b0, 1'b1, 2'd0, 24'h123456);
    check_eq("first_h", 64'(h_cnt), 64'd0);
    check_eq("first_v", 64'(v_cnt), 64'd0);
    check_eq("first_dv", 64'(dv_o), 64'd1);
    check_eq("first_fs", 64'(frame_start_o), 64'd1);
    check_eq("first_rgb", 64'({red_o, green_o, blue_o}), 64'h123456);
    for (int i = 1; i < 2 * FRAME; i++) step(1'b0, 1'b1, 2'd0, 24'h123456);

    // Colour bars: selected now, visible from the next frame
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b1, 2'd2, 24'h123456);
      if (h_cnt == 11'd2 && v_cnt == 11'd1 && i >= FRAME)
        check_eq("bar_yellow", 64'({red_o, green_o, blue_o}), 64'hFFFF00);
    end

    // Solid frame, switch to ramp at v=2: ramp starts at the next frame
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, (i < 2 * HT) ? 2'd2 : 2'd0, 24'hA5C33C);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, (i < 2 * HT) ? 2'd0 : 2'd1, 24'hA5C33C);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 2'd1, 24'hA5C33C);

    // Drop enable mid-frame at (7,1), idle, then restart
    while (!(m_h == 7 && m_v == 1)) step(1'b0, 1'b1, 2'd1, 24'h0);
    step(1'b0, 1'b1, 2'd1, 24'h0);
    step(1'b0, 1'b0, 2'd1, 24'h0);
    check_eq("abort_h", 64'(h_cnt), 64'd0);
    check_eq("abort_dv", 64'(dv_o), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd3, 24'h0);
    step(1'b0, 1'b1, 2'd3, 24'h0);
    check_eq("restart_fs", 64'(frame_start_o), 64'd1);

    // Long run: mixed patterns with mid-frame changes, frame counter wraps 255->0
    pat = 2'd3;
    sol = 24'h0;
    for (int f = 0; f < 260; f++) begin
      for (int i = (f == 0) ? 1 : 0; i < FRAME; i++) begin
        if (i == 100) begin
          pat = (f >= 250) ? 2'd1 : 2'(f + 1);
          sol = 24'($urandom);
        end
        step(1'b0, 1'b1, pat, sol);
        if (f == 256 && h_cnt == 11'd0 && v_cnt == 11'd0)
          check_eq("fc_wrap_b", 64'(blue_o), 64'd0);
      end
    end

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
